// File: rtl/game_timer_pkg.sv
// Shared constants for the whack-a-mole round timer: state encodings and count direction.
package game_timer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_RUN     = ST_RUN,
        S_PAUSED  = ST_PAUSED,
        S_EXPIRED = ST_EXPIRED
    } state_e;

endpackage

// File: rtl/game_timer_if.sv
// Control/status bundle between the game FSM (master) and the round timer (slave).
// GAME_TIMER_BCD_EN adds the decimal display digits bcd_tens/bcd_ones.
interface game_timer_if #(parameter int WIDTH = 6);

    logic             tick;
    logic             start;
    logic             pause;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             running;
    logic             expired;
    logic             tc_pulse;
`ifdef GAME_TIMER_BCD_EN
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;

    modport master (
        output tick, start, pause, clear, load, load_val, dir,
        input  count, state, running, expired, tc_pulse, bcd_tens, bcd_ones
    );
    modport slave (
        input  tick, start, pause, clear, load, load_val, dir,
        output count, state, running, expired, tc_pulse, bcd_tens, bcd_ones
    );
`else
    modport master (
        output tick, start, pause, clear, load, load_val, dir,
        input  count, state, running, expired, tc_pulse
    );
    modport slave (
        input  tick, start, pause, clear, load, load_val, dir,
        output count, state, running, expired, tc_pulse
    );
`endif

endinterface

// File: rtl/game_timer_bin2bcd.sv
// Combinational split of the timer count into tens/ones decimal digits for the display.
// Only built when GAME_TIMER_BCD_EN is defined.
`ifdef GAME_TIMER_BCD_EN
module timer_bin2bcd #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] bin,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    assign quot = bin / WIDTH'(10);
    assign rem  = bin % WIDTH'(10);
    assign tens = 4'(quot);
    assign ones = 4'(rem);

endmodule
`endif

// File: rtl/game_timer.sv
// Round timer: tick-strobed up/down counter with load, pause, saturate-or-wrap terminal and tc pulse.
// Optional macro GAME_TIMER_BCD_EN adds decimal digit outputs through timer_bin2bcd.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int MAX_COUNT = 59,
    parameter int WRAP      = 0
) (
    input  logic         clk,
    input  logic         rst,
    game_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    if (MAX_COUNT > (2 ** WIDTH) - 1) begin : g_max_check
        $error("game_timer: MAX_COUNT does not fit in WIDTH bits");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] load_clamped;
    logic             at_term;
    logic             next_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // An up count sitting above MAX_COUNT is treated as already terminal.
    always_comb begin
        at_term      = (bus.dir == DIR_DOWN) ? (count_q == '0) : (count_q >= MAX_C);
        step_val     = (bus.dir == DIR_DOWN) ? (count_q - ONE) : (count_q + ONE);
        next_term    = (bus.dir == DIR_DOWN) ? (step_val == '0) : (step_val >= MAX_C);
        reload_val   = (bus.dir == DIR_DOWN) ? MAX_C : '0;
        load_clamped = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.clear) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (bus.load) begin
            state_d = S_IDLE;
            count_d = load_clamped;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.pause) begin
                        if (WRAP == 0 && at_term) begin
                            state_d = S_EXPIRED;
                            tc_d    = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_PAUSED;
                    end else if (bus.tick) begin
                        if (WRAP != 0) begin
                            tc_d    = at_term;
                            count_d = at_term ? reload_val : step_val;
                        end else if (at_term) begin
                            state_d = S_EXPIRED;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = step_val;
                            if (next_term) begin
                                state_d = S_EXPIRED;
                                tc_d    = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (bus.start && !bus.pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.state    = state_q;
    assign bus.running  = (state_q == S_RUN);
    assign bus.expired  = (state_q == S_EXPIRED);
    assign bus.tc_pulse = tc_q;

`ifdef GAME_TIMER_BCD_EN
    if (MAX_COUNT > 99) begin : g_bcd_check
        $error("game_timer: BCD output needs MAX_COUNT <= 99");
    end

    timer_bin2bcd #(.WIDTH(WIDTH)) u_bin2bcd (
        .bin  (count_q),
        .tens (bus.bcd_tens),
        .ones (bus.bcd_ones)
    );
`endif

endmodule
